// File: rtl/divsqrt_req_issuer.sv
// Initiator-side front end for the recoded-float divide/sqrt unit.
// Tagged requests are queued in a small circular FIFO, issued one at a time
// to the unit, and the unit's one-cycle result pulse is captured into a
// single result register that is handed out over a valid/ready channel.
// A request is only issued when the result register is free (or being
// drained this cycle), so the unit's outValid never needs back-pressure.
module divsqrt_req_issuer #(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int tagWidth = 4,
  parameter int reqDepth = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  // request channel
  output logic                         req_ready,
  input  logic                         req_valid,
  input  logic                         req_sqrtOp,
  input  logic [expWidth+sigWidth:0]   req_a,
  input  logic [expWidth+sigWidth:0]   req_b,
  input  logic [2:0]                   req_roundingMode,
  input  logic [tagWidth-1:0]          req_tag,
  // divide/sqrt unit interface
  input  logic                         unit_inReady,
  output logic                         unit_inValid,
  output logic                         unit_sqrtOp,
  output logic [expWidth+sigWidth:0]   unit_a,
  output logic [expWidth+sigWidth:0]   unit_b,
  output logic [2:0]                   unit_roundingMode,
  input  logic                         unit_outValid,
  input  logic                         unit_sqrtOpOut,
  input  logic [expWidth+sigWidth:0]   unit_out,
  input  logic [4:0]                   unit_exceptionFlags,
  // response channel
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_sqrtOp,
  output logic [expWidth+sigWidth:0]   resp_out,
  output logic [4:0]                   resp_exceptionFlags,
  output logic [tagWidth-1:0]          resp_tag,
  // status
  output logic                         busy,
  output logic                         protocol_err
);

  localparam int OPW   = expWidth + sigWidth + 1;
  localparam int PTR_W = (reqDepth > 1) ? $clog2(reqDepth) : 1;
  localparam int CNT_W = $clog2(reqDepth + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                sqrt_op;
    logic [OPW-1:0]      a;
    logic [OPW-1:0]      b;
    logic [2:0]          rm;
    logic [tagWidth-1:0] tag;
  } entry_t;

  // Advance a FIFO pointer, wrapping modulo reqDepth (depth need not be 2^n).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] nxt;
    if (p == PTR_W'(reqDepth - 1)) begin
      nxt = '0;
    end else begin
      nxt = p + 1'b1;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,       state_d;

  entry_t              fifo_q [reqDepth];
  entry_t              fifo_d [reqDepth];
  logic [PTR_W-1:0]    wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]    count_q,       count_d;

  // issue register: everything the unit sees, plus the tag kept for the result
  logic                unit_inValid_q, unit_inValid_d;
  logic                iss_sqrt_q,    iss_sqrt_d;
  logic [OPW-1:0]      iss_a_q,       iss_a_d;
  logic [OPW-1:0]      iss_b_q,       iss_b_d;
  logic [2:0]          iss_rm_q,      iss_rm_d;
  logic [tagWidth-1:0] iss_tag_q,     iss_tag_d;

  // result register
  logic                resp_valid_q,  resp_valid_d;
  logic                res_sqrt_q,    res_sqrt_d;
  logic [OPW-1:0]      res_out_q,     res_out_d;
  logic [4:0]          res_flags_q,   res_flags_d;
  logic [tagWidth-1:0] res_tag_q,     res_tag_d;

  logic                protocol_err_q, protocol_err_d;

  // ---------------------------------------------------------------------------
  // Handshake decodes
  // ---------------------------------------------------------------------------
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   resp_take;
  logic   slot_free;
  logic   start_issue;
  logic   capture;

  assign head       = fifo_q[rd_ptr_q];
  // Full/empty come from the registered count only: a pop this cycle does
  // not open room for a push this cycle.
  assign fifo_full  = (count_q >= CNT_W'(reqDepth));
  assign fifo_empty = (count_q == '0);
  assign push       = req_valid && !fifo_full;
  assign resp_take  = resp_valid_q && resp_ready;
  // The result register is free if empty or being drained in this very cycle.
  assign slot_free  = !resp_valid_q || resp_ready;
  assign start_issue = (state_q == ST_IDLE) && !fifo_empty && slot_free;
  assign capture    = (state_q == ST_WAIT) && unit_outValid;

  // Next-state logic for the FIFO, the FSM, the issue and result registers.
  always_comb begin
    state_d        = state_q;
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    unit_inValid_d = unit_inValid_q;
    iss_sqrt_d     = iss_sqrt_q;
    iss_a_d        = iss_a_q;
    iss_b_d        = iss_b_q;
    iss_rm_d       = iss_rm_q;
    iss_tag_d      = iss_tag_q;
    resp_valid_d   = resp_valid_q;
    res_sqrt_d     = res_sqrt_q;
    res_out_d      = res_out_q;
    res_flags_d    = res_flags_q;
    res_tag_d      = res_tag_q;
    protocol_err_d = protocol_err_q;

    // request FIFO
    if (push) begin
      fifo_d[wr_ptr_q] = '{sqrt_op: req_sqrtOp, a: req_a, b: req_b,
                           rm: req_roundingMode, tag: req_tag};
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (start_issue) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(start_issue);

    // consumer drains the held result
    if (resp_take) begin
      resp_valid_d = 1'b0;
    end

    // a result pulse outside WAIT is dropped but flagged
    if (unit_outValid && (state_q != ST_WAIT)) begin
      protocol_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_issue) begin
          state_d        = ST_ISSUE;
          unit_inValid_d = 1'b1;
          iss_sqrt_d     = head.sqrt_op;
          iss_a_d        = head.a;
          iss_b_d        = head.b;
          iss_rm_d       = head.rm;
          iss_tag_d      = head.tag;
        end
      end
      ST_ISSUE: begin
        // operands and inValid are held untouched until the unit accepts
        if (unit_inReady) begin
          state_d        = ST_WAIT;
          unit_inValid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (capture) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          res_sqrt_d   = unit_sqrtOpOut;
          res_out_d    = unit_out;
          res_flags_d  = unit_exceptionFlags;
          res_tag_d    = iss_tag_q;
          if (unit_sqrtOpOut != iss_sqrt_q) begin
            protocol_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d        = ST_IDLE;
        unit_inValid_d = 1'b0;
      end
    endcase
  end

  // All state registers; reset clears control and zeroes data so outputs are deterministic.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < reqDepth; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      unit_inValid_q <= 1'b0;
      iss_sqrt_q     <= 1'b0;
      iss_a_q        <= '0;
      iss_b_q        <= '0;
      iss_rm_q       <= '0;
      iss_tag_q      <= '0;
      resp_valid_q   <= 1'b0;
      res_sqrt_q     <= 1'b0;
      res_out_q      <= '0;
      res_flags_q    <= '0;
      res_tag_q      <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      unit_inValid_q <= unit_inValid_d;
      iss_sqrt_q     <= iss_sqrt_d;
      iss_a_q        <= iss_a_d;
      iss_b_q        <= iss_b_d;
      iss_rm_q       <= iss_rm_d;
      iss_tag_q      <= iss_tag_d;
      resp_valid_q   <= resp_valid_d;
      res_sqrt_q     <= res_sqrt_d;
      res_out_q      <= res_out_d;
      res_flags_q    <= res_flags_d;
      res_tag_q      <= res_tag_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready           = !fifo_full;

  assign unit_inValid        = unit_inValid_q;
  assign unit_sqrtOp         = iss_sqrt_q;
  assign unit_a              = iss_a_q;
  assign unit_b              = iss_b_q;
  assign unit_roundingMode   = iss_rm_q;

  assign resp_valid          = resp_valid_q;
  assign resp_sqrtOp         = res_sqrt_q;
  assign resp_out            = res_out_q;
  assign resp_exceptionFlags = res_flags_q;
  assign resp_tag            = res_tag_q;

  assign busy                = !fifo_empty || (state_q != ST_IDLE) || resp_valid_q;
  assign protocol_err        = protocol_err_q;

endmodule
